alu_issue_arbiter: RTL and testbench

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_issue_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: two-slot round-robin issue arbiter feeding a
// single-cycle ALU. One registered result slot sits on a valid/ready
// result bus. A flush drops the pending result and blocks grants for
// that cycle. A saturating counter records result-bus backpressure.
module alu_issue_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [3:0]            req0_op,
  input  logic [3:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [4:0]            req0_shamt,
  input  logic [4:0]            req1_shamt,
  input  logic [TAG_WIDTH-1:0]  req0_tag,
  input  logic [TAG_WIDTH-1:0]  req1_tag,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  input  logic                  out_ready,
  output logic [15:0]           stall_cnt
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_SGT = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;

  // Single-cycle ALU; unused encodings produce zero.
  function automatic logic [DATA_WIDTH-1:0] alu_compute(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [4:0]            shamt
  );
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SGT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = b << shamt;
      OP_SRL:  r = b >> shamt;
      default: r = {DATA_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  logic                  out_valid_q,  out_valid_d;
  logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_WIDTH-1:0]  out_tag_q,    out_tag_d;
  logic                  rr_ptr_q,     rr_ptr_d;
  logic [15:0]           stall_cnt_q,  stall_cnt_d;

  logic                  can_accept_s;
  logic                  grant_any_s;
  logic                  grant_idx_s;
  logic                  xfer_s;
  logic [3:0]            sel_op_s;
  logic [DATA_WIDTH-1:0] sel_a_s;
  logic [DATA_WIDTH-1:0] sel_b_s;
  logic [4:0]            sel_shamt_s;
  logic [TAG_WIDTH-1:0]  sel_tag_s;

  // Round-robin grant: lone requester wins, a tie goes to rr_ptr.
  // Grants are withheld while reset is asserted.
  always_comb begin
    can_accept_s = (!out_valid_q || out_ready) && !flush && rst;
    grant_any_s  = 1'b0;
    grant_idx_s  = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_any_s = 1'b1;
        grant_idx_s = 1'b0;
      end
      2'b10: begin
        grant_any_s = 1'b1;
        grant_idx_s = 1'b1;
      end
      2'b11: begin
        grant_any_s = 1'b1;
        grant_idx_s = rr_ptr_q;
      end
      default: begin
        grant_any_s = 1'b0;
        grant_idx_s = 1'b0;
      end
    endcase
    xfer_s = can_accept_s && grant_any_s;
    if (xfer_s) begin
      req_ready = grant_idx_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Route the granted slot's payload to the ALU.
  always_comb begin
    if (grant_idx_s) begin
      sel_op_s    = req1_op;
      sel_a_s     = req1_a;
      sel_b_s     = req1_b;
      sel_shamt_s = req1_shamt;
      sel_tag_s   = req1_tag;
    end else begin
      sel_op_s    = req0_op;
      sel_a_s     = req0_a;
      sel_b_s     = req0_b;
      sel_shamt_s = req0_shamt;
      sel_tag_s   = req0_tag;
    end
  end

  // Next state for the result register, pointer and stall counter.
  // Flush has priority: it drops the pending result whatever out_ready says.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    rr_ptr_d     = rr_ptr_q;
    stall_cnt_d  = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer_s) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_compute(sel_op_s, sel_a_s, sel_b_s, sel_shamt_s);
      out_tag_d    = sel_tag_s;
      rr_ptr_d     = ~grant_idx_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (out_valid_q && !out_ready && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= {DATA_WIDTH{1'b0}};
      out_tag_q    <= {TAG_WIDTH{1'b0}};
      rr_ptr_q     <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      rr_ptr_q     <= rr_ptr_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: a reference model of the
// arbiter predicts grants, and a queue scoreboard holds the expected
// results until the result bus delivers them.
module tb_alu_issue_arbiter;

  localparam int DW = 32;
  localparam int TW = 6;

  logic          clk;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [3:0]    req0_op, req1_op;
  logic [DW-1:0] req0_a, req1_a, req0_b, req1_b;
  logic [4:0]    req0_shamt, req1_shamt;
  logic [TW-1:0] req0_tag, req1_tag;
  logic          flush;
  logic          out_valid;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic          out_ready;
  logic [15:0]   stall_cnt;

  alu_issue_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a),
    .req0_b(req0_b), .req1_b(req1_b),
    .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
    .req0_tag(req0_tag), .req1_tag(req1_tag),
    .flush(flush),
    .out_valid(out_valid), .out_result(out_result), .out_tag(out_tag),
    .out_ready(out_ready),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    sh;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_rr     = 1'b0;
  int   m_stall  = 0;
  logic use_ovr  = 1'b0;
  logic [DW-1:0] ovr_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [4:0] sh);
    logic lt, gt;
    lt = (a[DW-1] != b[DW-1]) ? a[DW-1] : (a < b);
    gt = (a[DW-1] != b[DW-1]) ? b[DW-1] : (a > b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a + ~b + 32'd1;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return lt ? 32'd1 : 32'd0;
      4'd5:    return gt ? 32'd1 : 32'd0;
      4'd6:    return ~(a | b);
      4'd7:    return a ^ b;
      4'd8:    return b << sh;
      4'd9:    return b >> sh;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_slot(input int s, input logic [3:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [4:0] sh, input logic [TW-1:0] tag);
    if (s == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh; req0_tag = tag;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh; req1_tag = tag;
    end
  endtask

  // Called at posedge+1 with inputs driven: checks at negedge, advances model, returns at next posedge+1.
  task automatic tick();
    logic       mv, can, any, g;
    logic [1:0] exp_rdy;
    exp_t       e;
    #4;
    mv  = (q.size() != 0);
    can = (!mv || out_ready) && !flush;
    any = (req_valid != 2'b00);
    g   = (req_valid == 2'b11) ? m_rr : (req_valid == 2'b10);
    exp_rdy = (can && any) ? (g ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, mv});
    if (mv) begin
      chk("out_result", {32'd0, out_result}, {32'd0, q[0].res});
      chk("out_tag", {58'd0, out_tag}, {58'd0, q[0].tag});
    end
    chk("stall_cnt", {48'd0, stall_cnt}, m_stall);
    if (mv && !out_ready && !flush && m_stall < 16'hFFFF) m_stall++;
    if (mv && (out_ready || flush)) void'(q.pop_front());
    if (can && any) begin
      if (g) begin
        e.res = alu_ref(req1_op, req1_a, req1_b, req1_shamt);
        e.tag = req1_tag;
      end else begin
        e.res = use_ovr ? ovr_val : alu_ref(req0_op, req0_a, req0_b, req0_shamt);
        e.tag = req0_tag;
      end
      q.push_back(e);
      m_rr = ~g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_rr = 1'b0;
    m_stall = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_result"}, {32'd0, out_result}, 64'd0);
    chk({tag, "_tag"}, {58'd0, out_tag}, 64'd0);
    chk({tag, "_stall"}, {48'd0, stall_cnt}, 64'd0);
    chk({tag, "_ready"}, {62'd0, req_ready}, 64'd0);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{4'd0, 32'd5,          32'd7,          5'd0,  32'd12};
    vecs[1]  = '{4'd1, 32'd5,          32'd7,          5'd0,  32'hFFFFFFFE};
    vecs[2]  = '{4'd2, 32'hF0F0F0F0,   32'hFF00FF00,   5'd0,  32'hF000F000};
    vecs[3]  = '{4'd3, 32'hF0F0F0F0,   32'hFF00FF00,   5'd0,  32'hFFF0FFF0};
    vecs[4]  = '{4'd4, 32'hFFFFFFFF,   32'd1,          5'd0,  32'd1};
    vecs[5]  = '{4'd5, 32'hFFFFFFFF,   32'd1,          5'd0,  32'd0};
    vecs[6]  = '{4'd6, 32'h0F0F0F0F,   32'h00FF00FF,   5'd0,  32'hF000F000};
    vecs[7]  = '{4'd7, 32'hAAAA5555,   32'hFFFF0000,   5'd0,  32'h55555555};
    vecs[8]  = '{4'd8, 32'd0,          32'd1,          5'd31, 32'h80000000};
    vecs[9]  = '{4'd9, 32'd0,          32'h80000000,   5'd31, 32'd1};
    vecs[10] = '{4'd15, 32'h12345678,  32'h9ABCDEF0,   5'd3,  32'd0};
    vecs[11] = '{4'd0, 32'hFFFFFFFF,   32'd1,          5'd0,  32'd0};
    vecs[12] = '{4'd4, 32'd1,          32'hFFFFFFFF,   5'd0,  32'd0};
    vecs[13] = '{4'd5, 32'd1,          32'hFFFFFFFF,   5'd0,  32'd1};
    vecs[14] = '{4'd10, 32'd5,         32'd7,          5'd0,  32'd0};

    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; req_valid = 2'b11;
    set_slot(0, 4'd0, 32'd0, 32'd0, 5'd0, 6'd0);
    set_slot(1, 4'd0, 32'd0, 32'd0, 5'd0, 6'd0);
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    check_reset_outputs("reset_edge");
    rst = 1'b1;

    // Both slots valid: ADD 5+7 tag 3 and SUB 5-7 tag 4, grants alternate.
    set_slot(0, 4'd0, 32'd5, 32'd7, 5'd0, 6'd3);
    set_slot(1, 4'd1, 32'd5, 32'd7, 5'd0, 6'd4);
    req_valid = 2'b11;
    repeat (4) tick();

    // Backpressure for 3 cycles, then release.
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (2) tick();

    // Table-driven ALU vectors through slot 0.
    req_valid = 2'b01;
    use_ovr = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_slot(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, TW'(i));
      ovr_val = vecs[i].exp;
      tick();
    end
    use_ovr = 1'b0;
    req_valid = 2'b00;
    tick();

    // Flush during backpressure with both slots valid.
    req_valid = 2'b11;
    tick();
    out_ready = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Slot 1 alone for a while, then slot 0 joins and wins the tie.
    req_valid = 2'b10;
    repeat (4) tick();
    req_valid = 2'b11;
    repeat (3) tick();

    // Randomised traffic with payload changes while waiting.
    for (int i = 0; i < 300; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      set_slot(0, 4'($urandom), $urandom, $urandom, 5'($urandom), 6'($urandom));
      set_slot(1, 4'($urandom), $urandom, $urandom, 5'($urandom), 6'($urandom));
      tick();
    end
    flush = 1'b0; out_ready = 1'b1; req_valid = 2'b00;
    repeat (2) tick();

    // Saturation of stall_cnt under long backpressure.
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    out_ready = 1'b0;
    tick();
    repeat (65540) @(posedge clk);
    #1;
    m_stall = (m_stall + 65540 > 65535) ? 65535 : m_stall + 65540;
    tick();
    chk("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);

    // Clean restart, build stall_cnt=5 with a pending result, then async reset mid-cycle.
    rst = 1'b0; #1; rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    out_ready = 1'b1;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    out_ready = 1'b0;
    repeat (5) tick();
    chk("stall_five", {48'd0, stall_cnt}, 64'd5);
    chk("pending_valid", {63'd0, out_valid}, 64'd1);
    req_valid = 2'b11;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    req_valid = 2'b00;
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b11;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
